// File: rtl/gf2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gf2_pkg
// Description : Shared types, constants and helpers for the GF(2) solution
//               pipeline blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package gf2_pkg;

   // Default solution vector width
   localparam int GF2_VARS_DEFAULT = 8;

   // Minimum-weight selector states
   typedef enum logic [0:0] {
      MIN_SEL__ACCUM = 1'b0,
      MIN_SEL__EMIT  = 1'b1
   } min_sel_state_t;

   // Saturating add of two unsigned values; result clamps at 2^width - 1.
   // The sum is formed one bit wider than the operands so the carry is seen.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned width);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << width) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_if
// Description : Minimal AXI-stream bundle (tvalid/tready/tdata/tlast).
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_stream_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/popcount.sv
`default_nettype none
// ============================================================================
// Module      : popcount
// Description : Counts set bits among the low n bits of vec_i.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount #(
   parameter int MAX_N = 8,
   parameter int MAX_W = $clog2(MAX_N + 1)
) (
   input  logic [MAX_N-1:0] vec_i,
   input  logic [MAX_W-1:0] n,
   output logic [MAX_W-1:0] count_o
);

   // Sum the active bits; bits at or above n are excluded
   always_comb begin
      count_o = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i < int'(n)) begin
            count_o = count_o + MAX_W'(vec_i[i]);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/gf2_min_weight_select.sv
`default_nettype none
// ============================================================================
// Module      : gf2_min_weight_select
// Description : Picks the minimum-Hamming-weight vector of each stream frame,
//               presents it on a valid/ready result port and keeps a running
//               total of frame minima plus a frame count.
// Revision    : 1.0 - initial release
// ============================================================================
module gf2_min_weight_select
   import gf2_pkg::*;
#(
   parameter int VARS     = GF2_VARS_DEFAULT,
   parameter int WEIGHT_W = $clog2(VARS + 1),
   parameter int CNT_W    = 9,
   parameter int TOTAL_W  = 16,
   parameter int FRAMES_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   axi_stream_if.slave         solution_stream,
   input  logic                clear,
   output logic                result_valid,
   input  logic                result_ready,
   output logic [VARS-1:0]     result_vector,
   output logic [WEIGHT_W-1:0] result_weight,
   output logic [CNT_W-1:0]    result_count,
   output logic [TOTAL_W-1:0]  total_presses,
   output logic [FRAMES_W-1:0] frames_done
);

   min_sel_state_t      state_q,    state_d;
   logic                first_q,    first_d;
   logic [VARS-1:0]     best_vec_q, best_vec_d;
   logic [WEIGHT_W-1:0] best_w_q,   best_w_d;
   logic [CNT_W-1:0]    count_q,    count_d;
   logic [VARS-1:0]     res_vec_q,  res_vec_d;
   logic [WEIGHT_W-1:0] res_w_q,    res_w_d;
   logic [CNT_W-1:0]    res_cnt_q,  res_cnt_d;
   logic [TOTAL_W-1:0]  total_q,    total_d;
   logic [FRAMES_W-1:0] frames_q,   frames_d;

   logic [VARS-1:0]     cand;
   logic [WEIGHT_W-1:0] cand_w;
   logic                beat_acc;
   logic                take;
   logic [VARS-1:0]     sel_vec;
   logic [WEIGHT_W-1:0] sel_w;
   logic [31:0]         cnt_wide;
   logic [31:0]         total_wide;
   logic [31:0]         frames_wide;
   logic                unused_bits;

   // Candidate is left-aligned in the byte; padding bits below it are dropped
   assign cand = solution_stream.tdata[7 -: VARS];

   popcount #(
      .MAX_N (VARS),
      .MAX_W (WEIGHT_W)
   ) u_popcount (
      .vec_i   (cand),
      .n       (WEIGHT_W'(VARS)),
      .count_o (cand_w)
   );

   // Ready depends on the registered state only, never on tvalid
   assign solution_stream.tready = (state_q == MIN_SEL__ACCUM);
   assign beat_acc = solution_stream.tvalid && (state_q == MIN_SEL__ACCUM);

   // Strict less-than keeps the earliest vector on ties
   assign take    = first_q || (cand_w < best_w_q);
   assign sel_vec = take ? cand   : best_vec_q;
   assign sel_w   = take ? cand_w : best_w_q;

   assign cnt_wide    = sat_add(32'(count_q),  32'd1,          CNT_W);
   assign total_wide  = sat_add(32'(total_q),  32'(res_w_q),   TOTAL_W);
   assign frames_wide = sat_add(32'(frames_q), 32'd1,          FRAMES_W);

   assign unused_bits = ^{total_wide[31:TOTAL_W], frames_wide[31:FRAMES_W],
                          cnt_wide[31:CNT_W], solution_stream.tdata};

   // Next-state: frame accumulation, result latch, handshake and totals
   always_comb begin
      state_d    = state_q;
      first_d    = first_q;
      best_vec_d = best_vec_q;
      best_w_d   = best_w_q;
      count_d    = count_q;
      res_vec_d  = res_vec_q;
      res_w_d    = res_w_q;
      res_cnt_d  = res_cnt_q;
      total_d    = total_q;
      frames_d   = frames_q;

      case (state_q)
         MIN_SEL__ACCUM: begin
            if (beat_acc) begin
               if (solution_stream.tlast) begin
                  res_vec_d = sel_vec;
                  res_w_d   = sel_w;
                  res_cnt_d = cnt_wide[CNT_W-1:0];
                  count_d   = '0;
                  first_d   = 1'b1;
                  state_d   = MIN_SEL__EMIT;
               end else begin
                  best_vec_d = sel_vec;
                  best_w_d   = sel_w;
                  count_d    = cnt_wide[CNT_W-1:0];
                  first_d    = 1'b0;
               end
            end
         end
         MIN_SEL__EMIT: begin
            if (result_ready) begin
               total_d  = total_wide[TOTAL_W-1:0];
               frames_d = frames_wide[FRAMES_W-1:0];
               state_d  = MIN_SEL__ACCUM;
            end
         end
         default: state_d = MIN_SEL__ACCUM;
      endcase

      // Clear overrides any same-cycle handshake accumulation
      if (clear) begin
         total_d  = '0;
         frames_d = '0;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= MIN_SEL__ACCUM;
         first_q    <= 1'b1;
         best_vec_q <= '0;
         best_w_q   <= '0;
         count_q    <= '0;
         res_vec_q  <= '0;
         res_w_q    <= '0;
         res_cnt_q  <= '0;
         total_q    <= '0;
         frames_q   <= '0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         best_vec_q <= best_vec_d;
         best_w_q   <= best_w_d;
         count_q    <= count_d;
         res_vec_q  <= res_vec_d;
         res_w_q    <= res_w_d;
         res_cnt_q  <= res_cnt_d;
         total_q    <= total_d;
         frames_q   <= frames_d;
      end
   end

   assign result_valid  = (state_q == MIN_SEL__EMIT);
   assign result_vector = res_vec_q;
   assign result_weight = res_w_q;
   assign result_count  = res_cnt_q;
   assign total_presses = total_q;
   assign frames_done   = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_gf2_min_weight_select.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf2_min_weight_select
// Description : Directed, table-driven bench for gf2_min_weight_select
//               (VARS=4, TOTAL_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf2_min_weight_select;

   localparam int VARS     = 4;
   localparam int WEIGHT_W = 3;
   localparam int CNT_W    = 9;
   localparam int TOTAL_W  = 4;
   localparam int FRAMES_W = 16;
   localparam int TOT_MAX  = 15;

   logic                clk = 1'b0;
   logic                rst;
   logic                clear;
   logic                result_valid;
   logic                result_ready;
   logic [VARS-1:0]     result_vector;
   logic [WEIGHT_W-1:0] result_weight;
   logic [CNT_W-1:0]    result_count;
   logic [TOTAL_W-1:0]  total_presses;
   logic [FRAMES_W-1:0] frames_done;

   axi_stream_if #(.DATA_WIDTH(8)) s_if ();

   gf2_min_weight_select #(
      .VARS     (VARS),
      .WEIGHT_W (WEIGHT_W),
      .CNT_W    (CNT_W),
      .TOTAL_W  (TOTAL_W),
      .FRAMES_W (FRAMES_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .solution_stream (s_if),
      .clear           (clear),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .result_vector   (result_vector),
      .result_weight   (result_weight),
      .result_count    (result_count),
      .total_presses   (total_presses),
      .frames_done     (frames_done)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int exp_total = 0;
   int exp_frames = 0;

   typedef struct {
      int              nb;
      logic [3:0][7:0] b;     // b[0] is the first beat
      logic [3:0]      vec;
      int              w;
      int              cnt;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Present one beat and hold it until accepted (bounded wait)
   task automatic send_beat(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = d;
      s_if.tlast  = l;
      while (!s_if.tready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) check("beat_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
   endtask

   // One-cycle result handshake, then check the running totals
   task automatic handshake(input int w);
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      exp_total  = (exp_total + w > TOT_MAX) ? TOT_MAX : exp_total + w;
      exp_frames = exp_frames + 1;
      check("total_presses", 32'(total_presses), 32'(exp_total));
      check("frames_done",   32'(frames_done),   32'(exp_frames));
      check("ready_after_hs", 32'(s_if.tready), 32'd1);
      check("valid_after_hs", 32'(result_valid), 32'd0);
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      exp_total  = 0;
      exp_frames = 0;
   endtask

   task automatic check_result(input logic [3:0] vec, input int w, input int cnt);
      check("result_valid",  32'(result_valid),  32'd1);
      check("result_vector", 32'(result_vector), 32'(vec));
      check("result_weight", 32'(result_weight), 32'(w));
      check("result_count",  32'(result_count),  32'(cnt));
   endtask

   initial begin
      // Directed frames; beats listed last-to-first within each packed literal
      tbl[0].nb = 4; tbl[0].b = {8'h30, 8'hF0, 8'h10, 8'hA0}; tbl[0].vec = 4'b0001; tbl[0].w = 1; tbl[0].cnt = 4;
      tbl[1].nb = 2; tbl[1].b = {8'h00, 8'h00, 8'hC0, 8'h30}; tbl[1].vec = 4'b0011; tbl[1].w = 2; tbl[1].cnt = 2;
      tbl[2].nb = 1; tbl[2].b = {8'h00, 8'h00, 8'h00, 8'h0F}; tbl[2].vec = 4'b0000; tbl[2].w = 0; tbl[2].cnt = 1;
      tbl[3].nb = 3; tbl[3].b = {8'h00, 8'hB0, 8'hE0, 8'h70}; tbl[3].vec = 4'b0111; tbl[3].w = 3; tbl[3].cnt = 3;
      tbl[4].nb = 1; tbl[4].b = {8'h00, 8'h00, 8'h00, 8'h8F}; tbl[4].vec = 4'b1000; tbl[4].w = 1; tbl[4].cnt = 1;

      rst = 1'b1; clear = 1'b0; result_ready = 1'b0;
      s_if.tvalid = 1'b0; s_if.tdata = 8'h00; s_if.tlast = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_valid",  32'(result_valid),  32'd0);
      check("rst_tready", 32'(s_if.tready),   32'd1);
      check("rst_total",  32'(total_presses), 32'd0);
      check("rst_frames", 32'(frames_done),   32'd0);
      check("rst_vector", 32'(result_vector), 32'd0);
      check("rst_count",  32'(result_count),  32'd0);

      // Backpressure: result held while tvalid is presented during EMIT
      send_beat(8'h60, 1'b1);
      s_if.tvalid = 1'b1; s_if.tdata = 8'h10; s_if.tlast = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_tready", 32'(s_if.tready),   32'd0);
         check("bp_valid",  32'(result_valid),  32'd1);
         check("bp_vector", 32'(result_vector), 32'b0110);
         check("bp_weight", 32'(result_weight), 32'd2);
         @(posedge clk); #1;
      end
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      exp_total = 2; exp_frames = 1;
      check("bp_total",  32'(total_presses), 32'd2);
      check("bp_frames", 32'(frames_done),   32'd1);
      check("bp_tready_back", 32'(s_if.tready), 32'd1);
      @(posedge clk); #1;
      s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
      check_result(4'b0001, 1, 1);
      handshake(1);

      // Table of frames, each starting from cleared totals
      pulse_clear();
      check("clear_total", 32'(total_presses), 32'd0);
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < tbl[k].nb; j++) begin
            check("valid_during_frame", 32'(result_valid), 32'd0);
            send_beat(tbl[k].b[j], (j == tbl[k].nb - 1));
         end
         check_result(tbl[k].vec, tbl[k].w, tbl[k].cnt);
         handshake(tbl[k].w);
      end

      // Total saturation at TOTAL_W=4
      pulse_clear();
      for (int k = 0; k < 4; k++) begin
         send_beat(8'hF0, 1'b1);
         check_result(4'b1111, 4, 1);
         handshake(4);
      end

      // Clear coinciding with a handshake wins
      send_beat(8'h80, 1'b1);
      result_ready = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0; clear = 1'b0;
      exp_total = 0; exp_frames = 0;
      check("clr_hs_total",  32'(total_presses), 32'd0);
      check("clr_hs_frames", 32'(frames_done),   32'd0);
      check("clr_hs_tready", 32'(s_if.tready),   32'd1);
      check("clr_hs_valid",  32'(result_valid),  32'd0);

      // Reset mid-frame discards the partial frame
      send_beat(8'h00, 1'b0);
      send_beat(8'h10, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_valid",  32'(result_valid), 32'd0);
      check("midrst_tready", 32'(s_if.tready),  32'd1);
      send_beat(8'h80, 1'b1);
      check_result(4'b1000, 1, 1);
      handshake(1);

      // Candidate counter saturates at 2^CNT_W - 1
      for (int i = 0; i < 511; i++) send_beat(8'h30, 1'b0);
      send_beat(8'h80, 1'b1);
      check_result(4'b1000, 1, 511);
      handshake(1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gf2_min_weight_select.md
# gf2_min_weight_select

Downstream consumer of the GF(2) solution enumerator's 8-bit AXI-stream. For each frame of candidate solution vectors (terminated by `tlast`), it finds the vector with minimum Hamming weight, i.e. the fewest button presses, and emits it on a valid/ready result port. It also keeps a running total of per-frame minima and a frame count across all frames, which together give the puzzle answer.

## Interface

Clocking: one clock; reset is synchronous and active-high.

Parameters:
- `VARS`, default 8: solution vector width. Range 1..8.
- `WEIGHT_W`, default `$clog2(VARS+1)`: width of a Hamming weight.
- `CNT_W`, default 9: width of the per-frame candidate counter. Holds up to 2^8.
- `TOTAL_W`, default 16: width of the running-total register.
- `FRAMES_W`, default 16: width of the frame counter.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `solution_stream`, `axi_stream_if` slave, `DATA_WIDTH` 8: candidates.
  - The vector is left-aligned in `tdata[7 -: VARS]`.
  - Lower bits are ignored.
- `clear`, in, 1: zero `total_presses` and `frames_done`.
- `result_valid`, out, 1: a frame result is available.
- `result_ready`, in, 1: downstream accepts the result.
- `result_vector`, out, VARS: the minimum-weight vector.
- `result_weight`, out, WEIGHT_W: popcount of `result_vector`.
- `result_count`, out, CNT_W: number of candidates in the frame. Saturating.
- `total_presses`, out, TOTAL_W: sum of accepted `result_weight`. Saturating.
- `frames_done`, out, FRAMES_W: number of accepted results. Saturating.

## Operation

States: `ACCUM`, `EMIT`.

ACCUM:
- `tready` = 1, `result_valid` = 0.
- On each accepted beat (`tvalid & tready`), compute w = popcount(`tdata[7 -: VARS]`).
- Update the best vector and best weight when either condition holds:
  - this is the first beat of the frame (`first` flag set), or
  - w < best weight (strict less-than).
- Ties keep the earliest vector.
- `count` increments on every accepted beat and saturates at 2^CNT_W − 1.
- When the accepted beat has `tlast` = 1:
  - Latch the final best vector, best weight and count, with that beat included, into the result registers.
  - Set `first` = 1 and go to EMIT.

EMIT:
- `tready` = 0, `result_valid` = 1.
- Result outputs are held stable until `result_valid & result_ready`.
- On the handshake:
  - `total_presses` += `result_weight`, saturating at all-ones.
  - `frames_done` += 1, saturating.
  - Return to ACCUM.

`clear`:
- Acts in any state.
- `total_presses` and `frames_done` become 0 on the next edge.
- When it coincides with a result handshake, clear wins: the handshake's weight is not added and the frame is not counted. The state transition still occurs.
- Frame accumulation and result registers are not affected.

Arithmetic:
- Popcount is over VARS bits and yields WEIGHT_W bits.
- The total is computed at TOTAL_W+1 bits, then clamped.

Reset:
- State = ACCUM, `first` = 1, `count` = 0.
- Result registers = 0.
- `result_valid` = 0, `tready` = 1 after reset deassertion.
- `total_presses` = 0, `frames_done` = 0.
- Reset mid-frame discards the partial frame. The next beat starts a new frame.

## Timing

- `result_valid` rises the cycle after the `tlast` beat is accepted. Latency is 1.
- `tready` is a registered function of state only. It does not depend combinationally on `tvalid`.
- Back-to-back frames:
  - There is one dead input cycle minimum, the EMIT cycle, when `result_ready` is held high.
  - A new frame's first beat can be accepted the cycle after the result handshake.
- Upstream may drive `tvalid` during EMIT. The beat is simply not accepted.
- `total_presses` and `frames_done` update the cycle after the handshake.

## Structure

- Shared package `gf2_pkg`:
  - state enum type `min_sel_state_t` {`MIN_SEL__ACCUM`, `MIN_SEL__EMIT`};
  - default `VARS` constant;
  - saturating-add helper function.
- Sub-module: instantiate the existing `popcount` block (`MAX_N` = VARS, `MAX_W` = WEIGHT_W, `n` = VARS) for w.
- No other hierarchy.

## Test plan

1. **Basic minimum.** VARS=4; beats 0xA0, 0x10, 0xF0, 0x30(last) → `result_vector`=4'b0001, `result_weight`=1, `result_count`=4. `result_valid` is high exactly one cycle after the last beat.
2. **Tie.** Beats 0x30, 0xC0(last) → `result_vector`=4'b0011, `result_weight`=2.
3. **Single-beat frame.** Beat 0x00(last) → weight 0, count 1. Lower padding bits 0x0F are set and must be ignored (weight stays 0).
4. **Backpressure.** `result_ready` held low 5 cycles with `tvalid` high → `tready`=0 and results stable. Raise `result_ready` → `total_presses` += weight and `frames_done`=1, and the next beat is accepted the following cycle.
5. **Saturation.** TOTAL_W=4; four frames each of weight 4 → `total_presses` = 4, 8, 12, 15 (saturated).
6. **Clear and reset.**
   - `clear` coincident with a result handshake → `total_presses`=0, `frames_done`=0, state ACCUM.
   - `rst` after 2 beats of a frame, then frame 0x80(last) → weight 1, count 1.
